// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame width and the
// baud divisor helper used by the TX/RX blocks.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic int calc_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIVISOR-1 while enabled and flags the last
// clk of each bit period. Shared between the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int DIVISOR = 434
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst_ || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/uart_tx_sva.sv
// Protocol checks for uart_tx, bound into every instance: bit timing,
// holding-register behaviour, tx_done pulse width and idle-high line.
module uart_tx_sva #(
  parameter int DIVISOR = 434
) (
  input logic       clk,
  input logic       rst_,
  input logic       tx_ready,
  input logic       tx_serial,
  input logic       tx_busy,
  input logic       tx_done,
  input logic       hold_valid,
  input logic [7:0] hold_data
);

  logic r_prev;
  logic r_armed;
  int   r_run;

  // Length of the current constant run on the line; the first edge after
  // reset is skipped because the high level before it may be short.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
      r_run   <= 0;
    end else begin
      r_prev <= tx_serial;
      if (tx_serial != r_prev) begin
        r_armed <= 1'b1;
        r_run   <= 1;
      end else if (r_run < DIVISOR) begin
        r_run <= r_run + 1;
      end
    end
  end

  a_bit_length: assert property (@(posedge clk) disable iff (rst_)
    (r_armed && (tx_serial != r_prev)) |-> (r_run >= DIVISOR));

  a_ready_mirror: assert property (@(posedge clk) disable iff (rst_)
    tx_ready == !hold_valid);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst_)
    (!rst_ && hold_valid) |=> $stable(hold_data));

  a_done_single: assert property (@(posedge clk) disable iff (rst_)
    tx_done |=> !tx_done);

  a_done_in_stop: assert property (@(posedge clk) disable iff (rst_)
    tx_done |-> (tx_busy && tx_serial));

  a_idle_high: assert property (@(posedge clk) disable iff (rst_)
    !tx_busy |-> tx_serial);

endmodule

bind uart_tx uart_tx_sva #(
  .DIVISOR(DIVISOR)
) u_uart_tx_sva (
  .clk       (clk),
  .rst_      (rst_),
  .tx_ready  (tx_ready),
  .tx_serial (tx_serial),
  .tx_busy   (tx_busy),
  .tx_done   (tx_done),
  .hold_valid(r_hold_valid),
  .hold_data (r_hold_data)
);

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register, so a second byte can
// be queued while the current frame is on the line (zero-gap back-to-back).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  tx_state_e r_state, w_state_next;

  logic                 r_hold_valid;
  logic [7:0]           r_hold_data;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_next;
  logic                 r_serial, w_serial_next;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_done;

  uart_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud_gen (
    .clk   (clk),
    .rst_  (rst_),
    .clear (r_state == ST_IDLE),
    .enable(r_state != ST_IDLE),
    .tick  (w_tick)
  );

  // Accept and drain are mutually exclusive: accept needs an empty holding
  // register, drain needs a full one.
  assign w_accept = tx_valid && !r_hold_valid && !rst_;

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= tx_data;
    end else if (w_drain) begin
      r_hold_valid <= 1'b0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_serial_next  = r_serial;
    w_drain        = 1'b0;
    w_done         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_serial_next = 1'b1;
        if (r_hold_valid) begin
          w_state_next   = ST_START;
          w_shift_next   = r_hold_data;
          w_bit_idx_next = '0;
          w_serial_next  = 1'b0;
          w_drain        = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next  = ST_DATA;
          w_serial_next = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            w_state_next  = ST_STOP;
            w_serial_next = 1'b1;
          end else begin
            w_shift_next   = r_shift >> 1;
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_serial_next  = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_done = 1'b1;
          // A queued byte goes straight into its start bit: no idle clks.
          if (r_hold_valid) begin
            w_state_next   = ST_START;
            w_shift_next   = r_hold_data;
            w_bit_idx_next = '0;
            w_serial_next  = 1'b0;
            w_drain        = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_serial_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_serial  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_serial  <= w_serial_next;
    end
  end

  assign tx_ready  = !r_hold_valid;
  assign tx_serial = r_serial;
  assign tx_busy   = (r_state != ST_IDLE);
  // A frame aborted by reset never reports completion.
  assign tx_done   = w_done && !rst_;

endmodule
